// File: rtl/multicycle_controller.sv
// RV32I multicycle control unit: Moore FSM plus combinational ALU and immediate decoders.
// Latency: 2 to 5 cycles per instruction; decoder outputs and the branch PC write are same-cycle combinational.
// Backpressure: none; the FSM advances every cycle and reset returns it to FETCH asynchronously.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control
);

  // FSM state encoding
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Datapath select encodings
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // ALU operation classes from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;

  // State register; reset lands in FETCH without waiting for a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DECODE and MEMADR branch on the opcode, everything else is fixed
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_FETCH;   // unsupported: drop without side effects
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;         // JAL then writes PC+4 to rd
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore outputs per state; anything not set for a state stays 0
  always_comb begin
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    branch     = 1'b0;
    pc_update  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write   = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        result_src = RES_ALUOUT;
        adr_src    = 1'b1;
        mem_write  = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNC;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNC;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
      end
      default: begin
        adr_src = 1'b0;
      end
    endcase
  end

  // PC load: zero feeds straight through so a late-settling compare still takes the branch this cycle
  always_comb begin
    pc_write = pc_update | (branch & zero);
  end

  // ALU decoder; sub for funct3 000 only on R-type (op[5]) with funct7b5, so addi never subtracts
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (funct3)
          3'b000:  alu_control = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // Immediate format select, from the opcode alone
  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed checks of the multicycle controller's per-cycle control outputs.
// Latency: inputs change 1 time unit after a rising edge, outputs are compared before the next edge.
// Backpressure: none; the bench steps one clock at a time with fixed cycle counts.
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic [15:0] obs;

  int tests_run;
  int tests_failed;

  multicycle_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output bundle: pcw adr mw irw rw rs[2] sa[2] sb[2] imm[2] alu[3]
  assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_control};

  function automatic logic [15:0] pk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] imm, input logic [2:0] ac);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, ac};
  endfunction

  task automatic chk(input string tag, input logic [15:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    op       = 7'b0110011;
    funct3   = 3'b000;
    funct7b5 = 1'b0;
    zero     = 1'b0;

    // Reset held for 3 cycles: FETCH outputs throughout
    step();
    chk("reset_hold", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000));
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("reset_release_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000));

    // add x3,x1,x2
    step(); chk("add_decode",   pk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
    step(); chk("add_executer", pk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000));
    step(); chk("add_aluwb",    pk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000));
    step(); chk("add_next_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000));

    // sub: same instruction with funct7b5=1
    funct7b5 = 1'b1;
    step(); chk("sub_decode",   pk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
    step(); chk("sub_executer", pk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001));
    step(); chk("sub_aluwb",    pk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000));
    step();

    // or (R-type funct3 110)
    funct7b5 = 1'b0; funct3 = 3'b110;
    step(); step(); chk("or_executer", pk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b011));
    step(); step();

    // addi with funct7b5=1: op[5]=0 so still add
    op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
    step(); step(); chk("addi_executei", pk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000));
    step(); chk("addi_aluwb",    pk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000));
    step();

    // slti / and-immediate
    funct3 = 3'b010; funct7b5 = 1'b0;
    step(); step(); chk("slti_executei", pk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b101));
    step(); step();
    funct3 = 3'b111;
    step(); step(); chk("andi_executei", pk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b010));
    step(); step();

    // lw: 5 cycles
    op = 7'b0000011; funct3 = 3'b010;
    chk("lw_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000));
    step(); chk("lw_decode",  pk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
    step(); chk("lw_memadr",  pk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000));
    step(); chk("lw_memread", pk(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000));
    step(); chk("lw_memwb",   pk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000));
    step(); chk("lw_next_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000));

    // sw: 4 cycles, single mem_write, no reg_write
    op = 7'b0100011;
    #1 chk("sw_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000));
    step(); chk("sw_decode",   pk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000));
    step(); chk("sw_memadr",   pk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000));
    step(); chk("sw_memwrite", pk(0,1,1,0,0,2'b00,2'b00,2'b00,2'b01,3'b000));
    step(); chk("sw_next_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b01,3'b000));

    // beq, zero changing within the BEQ cycle
    op = 7'b1100011; funct3 = 3'b000; zero = 1'b0;
    step(); chk("beq_decode", pk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000));
    step(); chk("beq_nottaken", pk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001));
    zero = 1'b1;
    #1 chk("beq_zero_rise", pk(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001));
    zero = 1'b0;
    #1 chk("beq_zero_fall", pk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001));
    step(); chk("beq_next_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000));
    zero = 1'b1;
    step(); step(); chk("beq_taken", pk(1,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001));
    step(); chk("beq_taken_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b10,3'b000));
    zero = 1'b0;

    // jal: JAL then ALUWB
    op = 7'b1101111;
    step(); chk("jal_decode", pk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000));
    step(); chk("jal_jal",    pk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000));
    step(); chk("jal_aluwb",  pk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b000));
    step(); chk("jal_next_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b11,3'b000));

    // Reset during EXECUTEI: immediate FETCH, no reg_write
    op = 7'b0010011; funct3 = 3'b000;
    step(); step(); chk("rst_mid_executei", pk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000));
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_async_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000));
    step(); chk("rst_mid_held", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000));
    rst_n = 1'b1;
    step(); chk("rst_mid_decode", pk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
    step(); step(); step();

    // Unsupported opcode: DECODE returns to FETCH
    op = 7'b1111111;
    #1 chk("bad_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000));
    step(); chk("bad_decode", pk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000));
    step(); chk("bad_back_fetch", pk(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
